pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised successor to the fixed 5-stage hazard controller.
- Takes per-stage stall/bubble requests and a single-pulse redirect source from any stage.
- Produces per-stage stall/flush controls plus the PC-load port for an N-stage in-order MIPS pipeline.
- Adds new sequential behaviour: a deferred-redirect register for redirects that arrive during a downstream stall, a sticky fetch-stall watchdog, and optional per-stage hazard statistics counters.

Parameters:
NUM_STAGES, 5, pipeline depth; stage 0 = fetch, stage NUM_STAGES-1 = writeback
ADDR_WIDTH, 32, PC width
CNT_WIDTH, 32, width of each statistics counter
WDOG_LIMIT, 1024, consecutive stage-0 stall cycles that trip the watchdog
SW, $clog2(NUM_STAGES), stage index width (derived, not overridable)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
stall_req  in  NUM_STAGES  stage i cannot advance this cycle
bubble_req  in  NUM_STAGES  stage i must emit a bubble while it stalls itself
redir_valid  in  1  single-cycle redirect pulse; the source does not hold it
redir_stage  in  SW  stage issuing the redirect; value 0 is illegal
redir_pc  in  ADDR_WIDTH  redirect target
stall_o  out  NUM_STAGES  hold stage i's input register
flush_o  out  NUM_STAGES  bubble into the register between stage i and stage i+1
load_pc_we  out  1  load PC this cycle
load_pc_new_pc  out  ADDR_WIDTH  PC value to load
redir_pending  out  1  a deferred redirect is held
wdog_trip  out  1  sticky watchdog flag
stat_stall_cnt  out  NUM_STAGES*CNT_WIDTH  per-stage stall-cycle counters; slice i = stage i
stat_redir_cnt  out  CNT_WIDTH  count of issued redirects

Behaviour:
- Reset is the only asynchronous path. While rst is high:
  - pend_valid/pend_stage/pend_pc = 0; wdog counter = 0; wdog_trip = 0; all stat counters = 0.
  - Because all requests are masked, stall_o = 0, flush_o = 0, load_pc_we = 0, load_pc_new_pc = 0.
- Stall chain (combinational):
  - stall_o[N-1] = stall_req[N-1].
  - stall_o[i] = stall_req[i] | stall_o[i+1].
  - A downstream stall has the highest priority.
- Bubble: flush_o[i] = stall_req[i] & bubble_req[i] & ~stall_o[i+1]. flush_o[N-1] is always 0.
- Effective redirect source:
  - The pending entry if pend_valid; otherwise the live pulse.
  - If both exist, the older one (higher stage index) wins. A tie goes to the pending entry.
  - A losing live pulse is dropped. It is wrong-path by construction.
- Issue condition: source stage s is issued when s == N-1 or ~stall_o[s+1]. On issue, in the same cycle:
  - load_pc_we = 1 and load_pc_new_pc = target.
  - For all j < s: stall_o[j] = 0 and flush_o[j] = 1. This overrides the bubble term.
  - pend_valid clears on the next clock.
- If the source is not issuable, the next clock captures it into pend_*. redir_pending = pend_valid.
  - The pending entry retries every cycle until issued. No timeout.
- Redirect FSM states:
  - IDLE: no pending entry.
  - HOLD: pending entry held, retrying each cycle.
  - IDLE->HOLD on an unissuable pulse. HOLD->IDLE on issue. HOLD->HOLD when an older live pulse replaces the entry.
- When nothing issues: load_pc_we = 0 and load_pc_new_pc = 0.
- Watchdog:
  - The counter increments while stall_o[0]; it clears when stall_o[0] is 0.
  - It saturates at WDOG_LIMIT. When it reaches WDOG_LIMIT, wdog_trip sets the next edge.
  - wdog_trip is sticky until rst.
- No X on any output when redir_valid = 0, regardless of redir_stage/redir_pc.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - stat_stall_cnt[i] increments each cycle stall_o[i] = 1.
  - stat_redir_cnt increments on each issue.
  - Counters saturate at all-ones. They clear only on rst.
- Undefined: both outputs are tied to 0 and no counter flops are instantiated.
- Under SIMULATION: emit stats_event("redirect_deferred") on capture and stats_event("wdog_trip") on trip, independent of the macro.

Test Plan:
- N=5, stall_req = 5'b00100, bubble_req = 5'b00100 -> stall_o = 5'b00111, flush_o = 5'b00100. All other flush_o bits 0.
- stall_req[3] = 1; redir_valid pulse with stage 2, pc 0x400100:
  - Pulse cycle: load_pc_we = 0. Next cycle: redir_pending = 1.
  - stall_req[3] drops at cycle 4 -> that cycle: load_pc_we = 1, new_pc = 0x400100, flush_o[1:0] = 2'b11.
  - Following cycle: redir_pending = 0.
- Pending stage 1 (pc 0xA0) plus a live pulse from stage 3 (pc 0xB0), downstream free -> issues 0xB0 with flush_o[2:0] = 3'b111. The stage-1 entry is discarded.
- Live pulse stage 2 while the pending entry is stage 2 -> the pending target is kept and the live pulse is ignored.
- WDOG_LIMIT = 8, stall_req[0] held for 8 cycles -> wdog_trip = 1 after cycle 8 and stays 1 after the stall drops. rst -> 0.
- HAZARD_STATS_EN defined, stall_req[4] held 3 cycles, then 2 redirects issued -> stat_stall_cnt slices 0..4 = 3 and stat_redir_cnt = 2. Assert rst mid-sequence -> all 0, redir_pending = 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for an N-stage in-order pipeline: combinational stall/flush/PC-load, one-entry deferred redirect, sticky watchdog.
// Redirects blocked by a downstream stall retry every cycle until issued; HAZARD_STATS_EN adds saturating per-stage statistics counters.
module pipe_hazard_ctrl #(
   parameter int NUM_STAGES = 5,
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 32,
   parameter int WDOG_LIMIT = 1024,
   localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_STAGES-1:0]           stall_req,
   input  logic [NUM_STAGES-1:0]           bubble_req,
   input  logic                            redir_valid,
   input  logic [SW-1:0]                   redir_stage,
   input  logic [ADDR_WIDTH-1:0]           redir_pc,
   output logic [NUM_STAGES-1:0]           stall_o,
   output logic [NUM_STAGES-1:0]           flush_o,
   output logic                            load_pc_we,
   output logic [ADDR_WIDTH-1:0]           load_pc_new_pc,
   output logic                            redir_pending,
   output logic                            wdog_trip,
   output logic [NUM_STAGES*CNT_WIDTH-1:0] stat_stall_cnt,
   output logic [CNT_WIDTH-1:0]            stat_redir_cnt
);

   localparam int WW = $clog2(WDOG_LIMIT + 1);
   localparam logic [WW-1:0] WLIM = WW'(WDOG_LIMIT);
   localparam logic [SW-1:0] LAST = SW'(NUM_STAGES - 1);
   localparam logic [NUM_STAGES-1:0] NOT_LAST = {1'b0, {(NUM_STAGES-1){1'b1}}};

   typedef enum logic {IDLE, HOLD} state_t;

   state_t                  state, state_nxt;
   logic                    pend_valid;
   logic [SW-1:0]           pend_stage;
   logic [ADDR_WIDTH-1:0]   pend_pc;
   logic [NUM_STAGES-1:0]   sreq, chain, down, flush_mask;
   logic                    live_ok, live_sel, src_valid, issue, capture;
   logic [SW-1:0]           src_stage;
   logic [ADDR_WIDTH-1:0]   src_pc;
   logic [WW-1:0]           wdog_cnt;

   assign pend_valid    = (state == HOLD);
   assign redir_pending = pend_valid;
   assign sreq          = rst ? '0 : stall_req;

   // Stall propagates upstream: a stage holds if it or anything after it stalls.
   always_comb begin
      chain = '0;
      chain[NUM_STAGES-1] = sreq[NUM_STAGES-1];
      for (int i = NUM_STAGES - 2; i >= 0; i--) begin
         chain[i] = sreq[i] | chain[i+1];
      end
   end

   assign down = chain >> 1;

   // Older (deeper) redirect wins; a tie keeps the pending entry.
   assign live_ok   = ~rst & redir_valid & (redir_stage != '0) & (redir_stage <= LAST);
   assign live_sel  = live_ok & (~pend_valid | (redir_stage > pend_stage));
   assign src_valid = live_sel | pend_valid;
   assign src_stage = live_sel ? redir_stage : pend_stage;
   assign src_pc    = live_sel ? redir_pc : pend_pc;
   assign issue     = src_valid & ~down[src_stage];
   assign capture   = src_valid & ~issue;

   always_comb begin
      flush_mask = '0;
      for (int j = 0; j < NUM_STAGES; j++) begin
         flush_mask[j] = issue & (SW'(j) < src_stage);
      end
   end

   assign stall_o        = chain & ~flush_mask;
   assign flush_o        = (sreq & bubble_req & ~down & NOT_LAST) | flush_mask;
   assign load_pc_we     = issue;
   assign load_pc_new_pc = issue ? src_pc : '0;

   always_comb begin
      state_nxt = IDLE;
      if (capture) state_nxt = HOLD;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         pend_stage <= '0;
         pend_pc    <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            pend_stage <= src_stage;
            pend_pc    <= src_pc;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wdog_cnt  <= '0;
         wdog_trip <= 1'b0;
      end else begin
         if (!stall_o[0]) wdog_cnt <= '0;
         else if (wdog_cnt != WLIM) wdog_cnt <= wdog_cnt + 1'b1;
         if (wdog_cnt == WLIM) wdog_trip <= 1'b1;
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_stall_cnt <= '0;
         stat_redir_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_STAGES; i++) begin
            if (stall_o[i] && (stat_stall_cnt[i*CNT_WIDTH +: CNT_WIDTH] != '1))
               stat_stall_cnt[i*CNT_WIDTH +: CNT_WIDTH] <= stat_stall_cnt[i*CNT_WIDTH +: CNT_WIDTH] + 1'b1;
         end
         if (issue && (stat_redir_cnt != '1)) stat_redir_cnt <= stat_redir_cnt + 1'b1;
      end
   end
`else
   assign stat_stall_cnt = '0;
   assign stat_redir_cnt = '0;
`endif

`ifdef SIMULATION
   int    sim_deferred_events = 0;
   int    sim_wdog_events     = 0;
   string sim_last_event      = "";

   task automatic stats_event(input string name);
      sim_last_event = name;
      if (name == "redirect_deferred") sim_deferred_events++;
      else if (name == "wdog_trip") sim_wdog_events++;
   endtask

   always @(posedge clk) begin
      if (!rst) begin
         if (capture) stats_event("redirect_deferred");
         if ((wdog_cnt == WLIM) && !wdog_trip) stats_event("wdog_trip");
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (N=5, WDOG_LIMIT=8): expectations queued per driven cycle, popped at the sampling edge.
module tb_pipe_hazard_ctrl;

   localparam int N  = 5;
   localparam int AW = 32;
   localparam int CW = 32;
   localparam int WL = 8;
   localparam int STATS_ON =
`ifdef HAZARD_STATS_EN
      1;
`else
      0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      stall_req, bubble_req;
   logic              redir_valid;
   logic [2:0]        redir_stage;
   logic [AW-1:0]     redir_pc;
   logic [N-1:0]      stall_o, flush_o;
   logic              load_pc_we;
   logic [AW-1:0]     load_pc_new_pc;
   logic              redir_pending, wdog_trip;
   logic [N*CW-1:0]   stat_stall_cnt;
   logic [CW-1:0]     stat_redir_cnt;

   pipe_hazard_ctrl #(.NUM_STAGES(N), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .WDOG_LIMIT(WL)) dut (
      .clk(clk), .rst(rst), .stall_req(stall_req), .bubble_req(bubble_req),
      .redir_valid(redir_valid), .redir_stage(redir_stage), .redir_pc(redir_pc),
      .stall_o(stall_o), .flush_o(flush_o), .load_pc_we(load_pc_we),
      .load_pc_new_pc(load_pc_new_pc), .redir_pending(redir_pending), .wdog_trip(wdog_trip),
      .stat_stall_cnt(stat_stall_cnt), .stat_redir_cnt(stat_redir_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string         tag;
      logic [N-1:0]  stall;
      logic [N-1:0]  flush;
      logic          we;
      logic [AW-1:0] pc;
      logic          pend;
      logic          trip;
      bit            trip_dc;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input string tag, input logic [N-1:0] sr, input logic [N-1:0] br,
                      input logic rv, input logic [2:0] rs, input logic [AW-1:0] rpc,
                      input logic [N-1:0] e_st, input logic [N-1:0] e_fl, input logic e_we,
                      input logic [AW-1:0] e_pc, input logic e_pend, input logic e_trip,
                      input bit trip_dc);
      exp_t e;
      stall_req   = sr;
      bubble_req  = br;
      redir_valid = rv;
      redir_stage = rs;
      redir_pc    = rpc;
      sb.push_back('{tag, e_st, e_fl, e_we, e_pc, e_pend, e_trip, trip_dc});
      @(negedge clk);
      e = sb.pop_front();
      check_eq({e.tag, ".stall"},   64'(stall_o),        64'(e.stall));
      check_eq({e.tag, ".flush"},   64'(flush_o),        64'(e.flush));
      check_eq({e.tag, ".pc_we"},   64'(load_pc_we),     64'(e.we));
      check_eq({e.tag, ".new_pc"},  64'(load_pc_new_pc), 64'(e.pc));
      check_eq({e.tag, ".pending"}, 64'(redir_pending),  64'(e.pend));
      if (!e.trip_dc) check_eq({e.tag, ".wdog"}, 64'(wdog_trip), 64'(e.trip));
      @(posedge clk);
      #1;
   endtask

   task automatic check_stats(input string tag, input int e_st, input int e_rd);
      for (int i = 0; i < N; i++) begin
         check_eq($sformatf("%s.stall_cnt%0d", tag, i), 64'(stat_stall_cnt[i*CW +: CW]), 64'(e_st));
      end
      check_eq({tag, ".redir_cnt"}, 64'(stat_redir_cnt), 64'(e_rd));
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within time budget");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      stall_req = '0; bubble_req = '0; redir_valid = 1'b0; redir_stage = '0; redir_pc = '0;
      #1;
      // Requests presented during reset must be fully masked.
      cyc("rst_mask0", 5'b11111, 5'b11111, 1, 3'd2, 32'h1234, 5'b0, 5'b0, 0, 32'h0, 0, 0, 0);
      cyc("rst_mask1", 5'b11111, 5'b11111, 1, 3'd4, 32'h5678, 5'b0, 5'b0, 0, 32'h0, 0, 0, 0);
      check_stats("rst", 0, 0);
      rst = 1'b0;
      cyc("idle", 5'b0, 5'b0, 0, 3'd0, 32'h0, 5'b0, 5'b0, 0, 32'h0, 0, 0, 0);

      cyc("chain_s2_bub", 5'b00100, 5'b00100, 0, 3'd0, 32'h0, 5'b00111, 5'b00100, 0, 32'h0, 0, 0, 0);
      cyc("chain_s2_nob", 5'b00100, 5'b00000, 0, 3'd0, 32'h0, 5'b00111, 5'b00000, 0, 32'h0, 0, 0, 0);
      cyc("chain_s3_bub", 5'b01000, 5'b01000, 0, 3'd0, 32'h0, 5'b01111, 5'b01000, 0, 32'h0, 0, 0, 0);
      cyc("chain_s4_bub", 5'b10000, 5'b10000, 0, 3'd0, 32'h0, 5'b11111, 5'b00000, 0, 32'h0, 0, 0, 0);
      cyc("chain_s12",    5'b00110, 5'b00110, 0, 3'd0, 32'h0, 5'b00111, 5'b00100, 0, 32'h0, 0, 0, 0);
      cyc("idle2", 5'b0, 5'b0, 0, 3'd0, 32'h0, 5'b0, 5'b0, 0, 32'h0, 0, 0, 0);

      // Redirect from stage 2 blocked by stage-3 stall, issued when it drops.
      cyc("defer_c1", 5'b01000, 5'b0, 1, 3'd2, 32'h400100, 5'b01111, 5'b0, 0, 32'h0, 0, 0, 0);
      cyc("defer_c2", 5'b01000, 5'b0, 0, 3'd0, 32'h0, 5'b01111, 5'b0, 0, 32'h0, 1, 0, 0);
      cyc("defer_c3", 5'b01000, 5'b0, 0, 3'd0, 32'h0, 5'b01111, 5'b0, 0, 32'h0, 1, 0, 0);
      cyc("defer_c4", 5'b00000, 5'b0, 0, 3'd0, 32'h0, 5'b00000, 5'b00011, 1, 32'h400100, 1, 0, 0);
      cyc("defer_c5", 5'b00000, 5'b0, 0, 3'd0, 32'h0, 5'b0, 5'b0, 0, 32'h0, 0, 0, 0);

      // Pending stage 1 overtaken by an older live pulse from stage 3.
      cyc("older_c1", 5'b00100, 5'b0, 1, 3'd1, 32'hA0, 5'b00111, 5'b0, 0, 32'h0, 0, 0, 0);
      cyc("older_c2", 5'b00000, 5'b0, 1, 3'd3, 32'hB0, 5'b00000, 5'b00111, 1, 32'hB0, 1, 0, 0);
      cyc("older_c3", 5'b00000, 5'b0, 0, 3'd0, 32'h0, 5'b0, 5'b0, 0, 32'h0, 0, 0, 0);

      // Tie on stage 2: pending target kept, live pulse dropped.
      cyc("tie_c1", 5'b01000, 5'b0, 1, 3'd2, 32'hC0, 5'b01111, 5'b0, 0, 32'h0, 0, 0, 0);
      cyc("tie_c2", 5'b01000, 5'b0, 1, 3'd2, 32'hD0, 5'b01111, 5'b0, 0, 32'h0, 1, 0, 0);
      cyc("tie_c3", 5'b00000, 5'b0, 0, 3'd0, 32'h0, 5'b00000, 5'b00011, 1, 32'hC0, 1, 0, 0);
      cyc("tie_c4", 5'b00000, 5'b0, 0, 3'd0, 32'h0, 5'b0, 5'b0, 0, 32'h0, 0, 0, 0);

      // Writeback redirect issues despite its own stall; stage-0 pulse is ignored.
      cyc("wb_issue", 5'b10000, 5'b0, 1, 3'd4, 32'hE0, 5'b10000, 5'b01111, 1, 32'hE0, 0, 0, 0);
      cyc("stage0_ign", 5'b00000, 5'b0, 1, 3'd0, 32'hF0, 5'b0, 5'b0, 0, 32'h0, 0, 0, 0);
      cyc("noredir_x", 5'b00000, 5'b0, 0, 3'd7, 'x, 5'b0, 5'b0, 0, 32'h0, 0, 0, 0);

      for (int k = 1; k <= WL; k++) begin
         cyc($sformatf("wdog_s%0d", k), 5'b00001, 5'b0, 0, 3'd0, 32'h0, 5'b00001, 5'b0, 0, 32'h0, 0, 0, 0);
      end
      cyc("wdog_rel",   5'b0, 5'b0, 0, 3'd0, 32'h0, 5'b0, 5'b0, 0, 32'h0, 0, 0, 1);
      cyc("wdog_stk1",  5'b0, 5'b0, 0, 3'd0, 32'h0, 5'b0, 5'b0, 0, 32'h0, 0, 1, 0);
      cyc("wdog_stk2",  5'b0, 5'b0, 0, 3'd0, 32'h0, 5'b0, 5'b0, 0, 32'h0, 0, 1, 0);
      rst = 1'b1;
      cyc("wdog_rst",   5'b0, 5'b0, 0, 3'd0, 32'h0, 5'b0, 5'b0, 0, 32'h0, 0, 0, 0);
      rst = 1'b0;

      for (int k = 1; k <= 3; k++) begin
         cyc($sformatf("stat_s%0d", k), 5'b10000, 5'b0, 0, 3'd0, 32'h0, 5'b11111, 5'b0, 0, 32'h0, 0, 0, 0);
      end
      cyc("stat_r1", 5'b0, 5'b0, 1, 3'd3, 32'h100, 5'b0, 5'b00111, 1, 32'h100, 0, 0, 0);
      cyc("stat_r2", 5'b0, 5'b0, 1, 3'd4, 32'h104, 5'b0, 5'b01111, 1, 32'h104, 0, 0, 0);
      cyc("stat_idle", 5'b0, 5'b0, 0, 3'd0, 32'h0, 5'b0, 5'b0, 0, 32'h0, 0, 0, 0);
      check_stats("stats", 3 * STATS_ON, 2 * STATS_ON);

      cyc("mid_c1", 5'b10000, 5'b0, 1, 3'd2, 32'h200, 5'b11111, 5'b0, 0, 32'h0, 0, 0, 0);
      cyc("mid_c2", 5'b10000, 5'b0, 0, 3'd0, 32'h0, 5'b11111, 5'b0, 0, 32'h0, 1, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      check_eq("midrst.pending", 64'(redir_pending), 64'd0);
      check_eq("midrst.stall",   64'(stall_o),       64'd0);
      check_eq("midrst.pc_we",   64'(load_pc_we),    64'd0);
      check_stats("midrst", 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc("post_rst", 5'b0, 5'b0, 0, 3'd0, 32'h0, 5'b0, 5'b0, 0, 32'h0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
